// File: rtl/i2c_mon_pkg.sv
// i2c_mon_pkg: shared definitions for the I2C clock-low timeout monitor.
//   - mon_state_t : monitor FSM state encoding
//   - LOW_MS_W / LOW_MS_MAX : width and saturation value of the ms counter
//   - TIMEOUT_MS_DEF / TICK_PER_MS_DEF : SMBus default timing constants
//   - ms_sat_inc : saturating increment of a ms count
package i2c_mon_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        COUNT    = 2'd2,
        STUCK    = 2'd3
    } mon_state_t;

    localparam int unsigned          LOW_MS_W   = 8;
    localparam logic [LOW_MS_W-1:0]  LOW_MS_MAX = 8'd255;

    localparam int unsigned TIMEOUT_MS_DEF  = 25;
    localparam int unsigned TICK_PER_MS_DEF = 1000;

    function automatic logic [LOW_MS_W-1:0] ms_sat_inc(input logic [LOW_MS_W-1:0] v);
        return (v == LOW_MS_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_scl_timeout_mon_if.sv
// i2c_scl_timeout_mon_if: bus/timer-side signals of the clock-low monitor.
//   master modport : the system side (drives enable, pin levels, tick, clear)
//   slave  modport : the monitor itself
//   mon_en, scl_in, sda_in, us_tick, stuck_clr      -> monitor
//   us_cnt_en, timeout_evt, bus_stuck, sda_stuck,
//   low_ms[LOW_MS_W-1:0]                             <- monitor
interface i2c_scl_timeout_mon_if;
    import i2c_mon_pkg::*;

    logic                mon_en;
    logic                scl_in;
    logic                sda_in;
    logic                us_tick;
    logic                stuck_clr;
    logic                us_cnt_en;
    logic                timeout_evt;
    logic                bus_stuck;
    logic                sda_stuck;
    logic [LOW_MS_W-1:0] low_ms;

    modport master (
        output mon_en, scl_in, sda_in, us_tick, stuck_clr,
        input  us_cnt_en, timeout_evt, bus_stuck, sda_stuck, low_ms
    );

    modport slave (
        input  mon_en, scl_in, sda_in, us_tick, stuck_clr,
        output us_cnt_en, timeout_evt, bus_stuck, sda_stuck, low_ms
    );

endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizer for one asynchronous I2C line.
//   sys_clk : system clock
//   sys_rst : synchronous active-high reset; both flops reset to 1 (idle bus)
//   line_i  : raw asynchronous pin level
//   line_o  : synchronized level, two cycles behind line_i
module i2c_line_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic line_i,
    output logic line_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

    assign line_o = sync_q;

endmodule

// File: rtl/i2c_scl_timeout_mon.sv
// i2c_scl_timeout_mon: SMBus-style SCL clock-low timeout monitor.
// While synchronized SCL is low the shared 1 us timer is enabled; its ticks
// are counted into milliseconds and a sticky stuck flag is raised once
// TIMEOUT_MS is reached.
//   Parameters : TICK_PER_MS (us ticks per ms, >=2), TIMEOUT_MS (1..255)
//   sys_clk    : system clock
//   sys_rst    : synchronous active-high reset
//   mon        : slave modport of i2c_scl_timeout_mon_if (see that file)
// Optional build macro SDA_STUCK_EN adds a second window timing SDA low while
// SCL is high; without it sda_stuck is tied to 0 and sda_in is ignored.
module i2c_scl_timeout_mon
    import i2c_mon_pkg::*;
#(
    parameter int unsigned TICK_PER_MS = TICK_PER_MS_DEF,
    parameter int unsigned TIMEOUT_MS  = TIMEOUT_MS_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    i2c_scl_timeout_mon_if.slave  mon
);

    localparam int unsigned          US_W    = $clog2(TICK_PER_MS);
    localparam logic [US_W-1:0]      US_LAST = US_W'(TICK_PER_MS - 1);
    localparam logic [LOW_MS_W-1:0]  LIMIT   = LOW_MS_W'(TIMEOUT_MS);

    logic scl_s;

    i2c_line_sync u_scl_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .line_i  (mon.scl_in),
        .line_o  (scl_s)
    );

    mon_state_t          state_q, state_d;
    logic [US_W-1:0]     us_cnt_q, us_cnt_d;
    logic [LOW_MS_W-1:0] low_ms_q, low_ms_d;
    logic                bus_stuck_q, bus_stuck_d;
    logic                timeout_evt_q, timeout_evt_d;
    logic                us_cnt_en_q, us_cnt_en_d;

    logic                scl_fire;
    logic                us_wrap;
    logic [US_W-1:0]     us_step;
    logic [LOW_MS_W-1:0] ms_step;

    // Contributions of the optional SDA window.
    logic                sda_fire;
    logic                sda_cnt_en;

    always_comb begin
        state_d     = state_q;
        us_cnt_d    = us_cnt_q;
        low_ms_d    = low_ms_q;
        bus_stuck_d = bus_stuck_q;
        scl_fire    = 1'b0;

        us_wrap = (us_cnt_q == US_LAST);
        us_step = us_wrap ? '0 : us_cnt_q + US_W'(1);
        ms_step = us_wrap ? ms_sat_inc(low_ms_q) : low_ms_q;

        if (!mon.mon_en) begin
            state_d     = IDLE;
            us_cnt_d    = '0;
            low_ms_d    = '0;
            bus_stuck_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = WAIT_LOW;
                    us_cnt_d = '0;
                    low_ms_d = '0;
                end
                WAIT_LOW: begin
                    if (!scl_s) begin
                        state_d  = COUNT;
                        us_cnt_d = '0;
                        low_ms_d = '0;
                    end
                end
                COUNT: begin
                    // SCL release takes priority over a coincident tick.
                    if (scl_s) begin
                        state_d  = WAIT_LOW;
                        us_cnt_d = '0;
                        low_ms_d = '0;
                    end else if (mon.us_tick) begin
                        us_cnt_d = us_step;
                        low_ms_d = ms_step;
                        if (us_wrap && (ms_step == LIMIT)) begin
                            state_d     = STUCK;
                            bus_stuck_d = 1'b1;
                            scl_fire    = 1'b1;
                        end
                    end
                end
                STUCK: begin
                    if (mon.stuck_clr) begin
                        state_d     = scl_s ? WAIT_LOW : COUNT;
                        us_cnt_d    = '0;
                        low_ms_d    = '0;
                        bus_stuck_d = 1'b0;
                    end else if (mon.us_tick) begin
                        us_cnt_d = us_step;
                        low_ms_d = ms_step;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        timeout_evt_d = scl_fire | sda_fire;
        us_cnt_en_d   = (state_d == COUNT) || (state_d == STUCK) || sda_cnt_en;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            us_cnt_q      <= '0;
            low_ms_q      <= '0;
            bus_stuck_q   <= 1'b0;
            timeout_evt_q <= 1'b0;
            us_cnt_en_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            us_cnt_q      <= us_cnt_d;
            low_ms_q      <= low_ms_d;
            bus_stuck_q   <= bus_stuck_d;
            timeout_evt_q <= timeout_evt_d;
            us_cnt_en_q   <= us_cnt_en_d;
        end
    end

`ifdef SDA_STUCK_EN
    logic                sda_s;
    logic                sda_win;
    logic [US_W-1:0]     sda_us_q, sda_us_d;
    logic [LOW_MS_W-1:0] sda_ms_q, sda_ms_d;
    logic                sda_stuck_q, sda_stuck_d;
    logic                sda_wrap;
    logic [LOW_MS_W-1:0] sda_ms_step;

    i2c_line_sync u_sda_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .line_i  (mon.sda_in),
        .line_o  (sda_s)
    );

    // Window is open while SDA is low with SCL high; leaving it (SDA rise or
    // SCL fall) restarts the count. Counting stops once the flag is set.
    always_comb begin
        sda_us_d    = sda_us_q;
        sda_ms_d    = sda_ms_q;
        sda_stuck_d = sda_stuck_q;
        sda_fire    = 1'b0;

        sda_win     = mon.mon_en && (state_q != IDLE) && scl_s && !sda_s;
        sda_wrap    = (sda_us_q == US_LAST);
        sda_ms_step = sda_wrap ? ms_sat_inc(sda_ms_q) : sda_ms_q;

        if (!mon.mon_en) begin
            sda_us_d    = '0;
            sda_ms_d    = '0;
            sda_stuck_d = 1'b0;
        end else if (mon.stuck_clr || !sda_win) begin
            sda_us_d = '0;
            sda_ms_d = '0;
            if (mon.stuck_clr) begin
                sda_stuck_d = 1'b0;
            end
        end else if (mon.us_tick && !sda_stuck_q) begin
            sda_us_d = sda_wrap ? '0 : sda_us_q + US_W'(1);
            sda_ms_d = sda_ms_step;
            if (sda_wrap && (sda_ms_step == LIMIT)) begin
                sda_stuck_d = 1'b1;
                sda_fire    = 1'b1;
            end
        end

        sda_cnt_en = sda_win && !sda_stuck_d;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sda_us_q    <= '0;
            sda_ms_q    <= '0;
            sda_stuck_q <= 1'b0;
        end else begin
            sda_us_q    <= sda_us_d;
            sda_ms_q    <= sda_ms_d;
            sda_stuck_q <= sda_stuck_d;
        end
    end

    assign mon.sda_stuck = sda_stuck_q;
`else
    logic sda_unused;

    assign sda_unused    = mon.sda_in;
    assign sda_fire      = 1'b0;
    assign sda_cnt_en    = 1'b0;
    assign mon.sda_stuck = 1'b0;
`endif

    assign mon.us_cnt_en   = us_cnt_en_q;
    assign mon.timeout_evt = timeout_evt_q;
    assign mon.bus_stuck   = bus_stuck_q;
    assign mon.low_ms      = low_ms_q;

endmodule
